// File: rtl/riscv_core_fetch_pc_gen_if.sv
// Fetch PC generator bus: instruction-memory request, predictor lookup,
// EX redirect and the fetch-info stream toward decode.
interface riscv_core_fetch_pc_gen_if #(
  parameter int PC_LEN = 64
);
  logic [PC_LEN-1:0] o_if_pc;
  logic              o_fetch_req;
  logic              i_fetch_ack;
  logic              i_branch_valid;
  logic              i_branch_taken;
  logic [PC_LEN-1:0] i_branch_target;
  logic              i_ex_redirect;
  logic [PC_LEN-1:0] i_ex_redirect_pc;
  logic              o_id_valid;
  logic              i_id_ready;
  logic [PC_LEN-1:0] o_id_pc;
  logic [PC_LEN-1:0] o_id_pred_target;
  logic              o_id_pred_taken;
  logic [15:0]       o_flush_count;

  modport master (
    output o_if_pc, o_fetch_req, o_id_valid, o_id_pc, o_id_pred_target,
           o_id_pred_taken, o_flush_count,
    input  i_fetch_ack, i_branch_valid, i_branch_taken, i_branch_target,
           i_ex_redirect, i_ex_redirect_pc, i_id_ready
  );

  modport slave (
    input  o_if_pc, o_fetch_req, o_id_valid, o_id_pc, o_id_pred_target,
           o_id_pred_taken, o_flush_count,
    output i_fetch_ack, i_branch_valid, i_branch_taken, i_branch_target,
           i_ex_redirect, i_ex_redirect_pc, i_id_ready
  );
endinterface

// File: rtl/riscv_core_fetch_pc_gen.sv
// Fetch PC generator with a 2-entry registered fetch-info queue toward decode.
// Branch prediction is used only when RISCV_CORE_FETCH_PRED_EN is defined.
//
// state  | meaning
// S_BOOT | one cycle after reset, no fetch, PC = RESET_PC
// S_RUN  | fetching whenever the queue has room
// S_HOLD | queue full, fetch stalled until decode pops
module riscv_core_fetch_pc_gen #(
  parameter int                PC_LEN   = 64,
  parameter logic [PC_LEN-1:0] RESET_PC = PC_LEN'(64'h0000_0000_8000_0000),
  parameter int                Q_DEPTH  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  riscv_core_fetch_pc_gen_if.master    bus
);

  localparam logic [1:0] Q_FULL = 2'(Q_DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [PC_LEN-1:0] r_if_pc, w_next_pc, w_seq_pc;
  logic              w_pred_taken, w_fetch_req, w_accept, w_pop;
  logic              r_hd_valid, r_hd_taken, r_q1_valid, r_q1_taken;
  logic [PC_LEN-1:0] r_hd_pc, r_hd_tgt, r_q1_pc, r_q1_tgt;
  logic [1:0]        w_count;
  logic              w_full;
  logic [15:0]       r_flush_cnt;

  assign w_seq_pc = r_if_pc + PC_LEN'(4);

`ifdef RISCV_CORE_FETCH_PRED_EN
  assign w_pred_taken = bus.i_branch_valid & bus.i_branch_taken;
  assign w_next_pc    = w_pred_taken ? (bus.i_branch_target & ~PC_LEN'(1)) : w_seq_pc;
`else
  logic w_pred_unused;
  assign w_pred_unused = ^{bus.i_branch_valid, bus.i_branch_taken, bus.i_branch_target};
  assign w_pred_taken  = 1'b0;
  assign w_next_pc     = w_seq_pc;
`endif

  assign w_count  = {1'b0, r_hd_valid} + {1'b0, r_q1_valid};
  assign w_full   = (w_count == Q_FULL);
  assign w_pop    = r_hd_valid & bus.i_id_ready & ~bus.i_ex_redirect;
  assign w_accept = w_fetch_req & bus.i_fetch_ack & ~bus.i_ex_redirect;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_BOOT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch_req = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        w_fetch_req = ~w_full & ~bus.i_ex_redirect;
        // The push that fills the last free slot moves us to HOLD
        if (w_fetch_req && bus.i_fetch_ack && !w_pop && (w_count == Q_FULL - 2'd1))
          w_state_nxt = S_HOLD;
      end
      S_HOLD: if (w_pop) w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
    if (bus.i_ex_redirect) w_state_nxt = S_RUN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_pc <= RESET_PC;
    end else if (bus.i_ex_redirect) begin
      r_if_pc <= bus.i_ex_redirect_pc & ~PC_LEN'(1);
    end else if (w_accept) begin
      r_if_pc <= w_next_pc;
    end
  end

  // Head register drives o_id_* directly; its payload is left untouched on
  // pop-to-empty and on flush so decode sees the last value held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hd_valid <= 1'b0;
      r_hd_pc    <= '0;
      r_hd_tgt   <= '0;
      r_hd_taken <= 1'b0;
      r_q1_valid <= 1'b0;
      r_q1_pc    <= '0;
      r_q1_tgt   <= '0;
      r_q1_taken <= 1'b0;
    end else if (bus.i_ex_redirect) begin
      r_hd_valid <= 1'b0;
      r_q1_valid <= 1'b0;
    end else if (w_pop) begin
      if (r_q1_valid) begin
        r_hd_pc    <= r_q1_pc;
        r_hd_tgt   <= r_q1_tgt;
        r_hd_taken <= r_q1_taken;
        r_q1_valid <= w_accept;
        if (w_accept) begin
          r_q1_pc    <= r_if_pc;
          r_q1_tgt   <= w_next_pc;
          r_q1_taken <= w_pred_taken;
        end
      end else if (w_accept) begin
        r_hd_pc    <= r_if_pc;
        r_hd_tgt   <= w_next_pc;
        r_hd_taken <= w_pred_taken;
      end else begin
        r_hd_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_hd_valid) begin
        r_hd_valid <= 1'b1;
        r_hd_pc    <= r_if_pc;
        r_hd_tgt   <= w_next_pc;
        r_hd_taken <= w_pred_taken;
      end else begin
        r_q1_valid <= 1'b1;
        r_q1_pc    <= r_if_pc;
        r_q1_tgt   <= w_next_pc;
        r_q1_taken <= w_pred_taken;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flush_cnt <= '0;
    end else if (bus.i_ex_redirect && (r_flush_cnt != 16'hFFFF)) begin
      r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign bus.o_if_pc          = r_if_pc;
  assign bus.o_fetch_req      = w_fetch_req;
  assign bus.o_id_valid       = r_hd_valid;
  assign bus.o_id_pc          = r_hd_pc;
  assign bus.o_id_pred_target = r_hd_tgt;
  assign bus.o_id_pred_taken  = r_hd_taken;
  assign bus.o_flush_count    = r_flush_cnt;

endmodule

// File: tb/tb_riscv_core_fetch_pc_gen.sv
// Directed bench for riscv_core_fetch_pc_gen: boot sequence, prediction,
// queue stall/resume, redirect, PC wrap, flush saturation and async reset.
module tb_riscv_core_fetch_pc_gen;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
`ifdef RISCV_CORE_FETCH_PRED_EN
  localparam logic [63:0] EXP_PRED_PC    = 64'h0000_0000_8000_0100;
  localparam logic        EXP_PRED_TAKEN = 1'b1;
`else
  localparam logic [63:0] EXP_PRED_PC    = 64'h0000_0000_8000_000C;
  localparam logic        EXP_PRED_TAKEN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  int          checks;
  int          errors;
  logic [15:0] exp_flush;

  riscv_core_fetch_pc_gen_if #(.PC_LEN(64)) u_if ();

  riscv_core_fetch_pc_gen u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (u_if.o_if_pc !== RST_PC) begin errors++; $display("FAIL rst_pc got %h exp %h", u_if.o_if_pc, RST_PC); end
    checks++; if (u_if.o_fetch_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", u_if.o_fetch_req); end
    checks++; if (u_if.o_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", u_if.o_id_valid); end
    checks++; if (u_if.o_flush_count !== 16'h0) begin errors++; $display("FAIL rst_flush got %h exp 0", u_if.o_flush_count); end
    checks++; if (u_if.o_id_pc !== 64'h0) begin errors++; $display("FAIL rst_id_pc got %h exp 0", u_if.o_id_pc); end
    checks++; if (u_if.o_id_pred_target !== 64'h0) begin errors++; $display("FAIL rst_id_tgt got %h exp 0", u_if.o_id_pred_target); end
    checks++; if (u_if.o_id_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_id_taken got %b exp 0", u_if.o_id_pred_taken); end
  endtask

  task automatic test_boot_seq();
    u_if.i_fetch_ack = 1'b1;
    u_if.i_id_ready  = 1'b1;
    rst_n = 1'b1;
    #1;
    checks++; if (u_if.o_fetch_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", u_if.o_fetch_req); end
    tick();
    checks++; if (u_if.o_if_pc !== 64'h8000_0000) begin errors++; $display("FAIL seq_pc0 got %h exp 80000000", u_if.o_if_pc); end
    checks++; if (u_if.o_fetch_req !== 1'b1) begin errors++; $display("FAIL seq_req got %b exp 1", u_if.o_fetch_req); end
    checks++; if (u_if.o_id_valid !== 1'b0) begin errors++; $display("FAIL seq_valid0 got %b exp 0", u_if.o_id_valid); end
    tick();
    checks++; if (u_if.o_if_pc !== 64'h8000_0004) begin errors++; $display("FAIL seq_pc1 got %h exp 80000004", u_if.o_if_pc); end
    checks++; if (u_if.o_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid1 got %b exp 1", u_if.o_id_valid); end
    checks++; if (u_if.o_id_pc !== 64'h8000_0000) begin errors++; $display("FAIL seq_id_pc1 got %h exp 80000000", u_if.o_id_pc); end
    checks++; if (u_if.o_id_pred_target !== 64'h8000_0004) begin errors++; $display("FAIL seq_id_tgt1 got %h exp 80000004", u_if.o_id_pred_target); end
    tick();
    checks++; if (u_if.o_if_pc !== 64'h8000_0008) begin errors++; $display("FAIL seq_pc2 got %h exp 80000008", u_if.o_if_pc); end
    checks++; if (u_if.o_id_pc !== 64'h8000_0004) begin errors++; $display("FAIL seq_id_pc2 got %h exp 80000004", u_if.o_id_pc); end
  endtask

  task automatic test_predict();
    u_if.i_branch_valid  = 1'b1;
    u_if.i_branch_taken  = 1'b1;
    u_if.i_branch_target = 64'h8000_0101;
    tick();
    u_if.i_branch_valid  = 1'b0;
    u_if.i_branch_taken  = 1'b0;
    u_if.i_branch_target = 64'h0;
    checks++; if (u_if.o_if_pc !== EXP_PRED_PC) begin errors++; $display("FAIL pred_pc got %h exp %h", u_if.o_if_pc, EXP_PRED_PC); end
    checks++; if (u_if.o_id_pc !== 64'h8000_0008) begin errors++; $display("FAIL pred_id_pc got %h exp 80000008", u_if.o_id_pc); end
    checks++; if (u_if.o_id_pred_target !== EXP_PRED_PC) begin errors++; $display("FAIL pred_id_tgt got %h exp %h", u_if.o_id_pred_target, EXP_PRED_PC); end
    checks++; if (u_if.o_id_pred_taken !== EXP_PRED_TAKEN) begin errors++; $display("FAIL pred_id_taken got %b exp %b", u_if.o_id_pred_taken, EXP_PRED_TAKEN); end
  endtask

  task automatic test_hold();
    u_if.i_ex_redirect    = 1'b1;
    u_if.i_ex_redirect_pc = 64'h8000_0200;
    #1;
    checks++; if (u_if.o_fetch_req !== 1'b0) begin errors++; $display("FAIL hold_redir_req got %b exp 0", u_if.o_fetch_req); end
    tick();
    exp_flush = exp_flush + 16'd1;
    u_if.i_ex_redirect = 1'b0;
    u_if.i_id_ready    = 1'b0;
    #1;
    checks++; if (u_if.o_if_pc !== 64'h8000_0200) begin errors++; $display("FAIL hold_pc0 got %h exp 80000200", u_if.o_if_pc); end
    checks++; if (u_if.o_id_valid !== 1'b0) begin errors++; $display("FAIL hold_valid0 got %b exp 0", u_if.o_id_valid); end
    checks++; if (u_if.o_fetch_req !== 1'b1) begin errors++; $display("FAIL hold_req0 got %b exp 1", u_if.o_fetch_req); end
    tick();
    checks++; if (u_if.o_if_pc !== 64'h8000_0204) begin errors++; $display("FAIL hold_pc1 got %h exp 80000204", u_if.o_if_pc); end
    checks++; if (u_if.o_fetch_req !== 1'b1) begin errors++; $display("FAIL hold_req1 got %b exp 1", u_if.o_fetch_req); end
    tick();
    checks++; if (u_if.o_fetch_req !== 1'b0) begin errors++; $display("FAIL hold_req2 got %b exp 0", u_if.o_fetch_req); end
    checks++; if (u_if.o_if_pc !== 64'h8000_0208) begin errors++; $display("FAIL hold_pc2 got %h exp 80000208", u_if.o_if_pc); end
    tick();
    checks++; if (u_if.o_fetch_req !== 1'b0) begin errors++; $display("FAIL hold_req3 got %b exp 0", u_if.o_fetch_req); end
    checks++; if (u_if.o_if_pc !== 64'h8000_0208) begin errors++; $display("FAIL hold_frozen got %h exp 80000208", u_if.o_if_pc); end
    checks++; if (u_if.o_id_pc !== 64'h8000_0200) begin errors++; $display("FAIL hold_id_pc got %h exp 80000200", u_if.o_id_pc); end
    u_if.i_id_ready = 1'b1;
    tick();
    checks++; if (u_if.o_fetch_req !== 1'b1) begin errors++; $display("FAIL resume_req got %b exp 1", u_if.o_fetch_req); end
    checks++; if (u_if.o_id_pc !== 64'h8000_0204) begin errors++; $display("FAIL resume_id_pc got %h exp 80000204", u_if.o_id_pc); end
    tick();
    checks++; if (u_if.o_if_pc !== 64'h8000_020C) begin errors++; $display("FAIL resume_pc got %h exp 8000020c", u_if.o_if_pc); end
    checks++; if (u_if.o_id_pc !== 64'h8000_0208) begin errors++; $display("FAIL resume_id_pc2 got %h exp 80000208", u_if.o_id_pc); end
    u_if.i_id_ready = 1'b0;
    tick();
    checks++; if (u_if.o_fetch_req !== 1'b0) begin errors++; $display("FAIL refill_req got %b exp 0", u_if.o_fetch_req); end
  endtask

  task automatic test_redirect();
    u_if.i_ex_redirect    = 1'b1;
    u_if.i_ex_redirect_pc = 64'h8000_1000;
    #1;
    checks++; if (u_if.o_fetch_req !== 1'b0) begin errors++; $display("FAIL redir_req got %b exp 0", u_if.o_fetch_req); end
    tick();
    exp_flush = exp_flush + 16'd1;
    u_if.i_ex_redirect = 1'b0;
    #1;
    checks++; if (u_if.o_id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", u_if.o_id_valid); end
    checks++; if (u_if.o_if_pc !== 64'h8000_1000) begin errors++; $display("FAIL redir_pc got %h exp 80001000", u_if.o_if_pc); end
    checks++; if (u_if.o_flush_count !== exp_flush) begin errors++; $display("FAIL redir_flush got %h exp %h", u_if.o_flush_count, exp_flush); end
    checks++; if (u_if.o_id_pc !== 64'h8000_0208) begin errors++; $display("FAIL redir_id_hold got %h exp 80000208", u_if.o_id_pc); end
    checks++; if (u_if.o_fetch_req !== 1'b1) begin errors++; $display("FAIL redir_run_req got %b exp 1", u_if.o_fetch_req); end
  endtask

  task automatic test_wrap();
    u_if.i_id_ready       = 1'b1;
    u_if.i_ex_redirect    = 1'b1;
    u_if.i_ex_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFD;
    tick();
    exp_flush = exp_flush + 16'd1;
    u_if.i_ex_redirect = 1'b0;
    checks++; if (u_if.o_if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h exp fffffffffffffffc", u_if.o_if_pc); end
    tick();
    checks++; if (u_if.o_if_pc !== 64'h0) begin errors++; $display("FAIL wrap_pc1 got %h exp 0", u_if.o_if_pc); end
    checks++; if (u_if.o_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_id_pc got %h exp fffffffffffffffc", u_if.o_id_pc); end
    checks++; if (u_if.o_id_pred_target !== 64'h0) begin errors++; $display("FAIL wrap_id_tgt got %h exp 0", u_if.o_id_pred_target); end
  endtask

  task automatic test_flush_sat();
    u_if.i_ex_redirect    = 1'b1;
    u_if.i_ex_redirect_pc = 64'h8000_0300;
    while (exp_flush != 16'hFFFE) begin
      tick();
      exp_flush = exp_flush + 16'd1;
    end
    checks++; if (u_if.o_flush_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got %h exp fffe", u_if.o_flush_count); end
    tick();
    checks++; if (u_if.o_flush_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got %h exp ffff", u_if.o_flush_count); end
    repeat (4) tick();
    checks++; if (u_if.o_flush_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", u_if.o_flush_count); end
    u_if.i_ex_redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    u_if.i_id_ready  = 1'b0;
    u_if.i_fetch_ack = 1'b1;
    tick();
    tick();
    checks++; if (u_if.o_id_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b exp 1", u_if.o_id_valid); end
    checks++; if (u_if.o_if_pc !== 64'h8000_0308) begin errors++; $display("FAIL ar_pre_pc got %h exp 80000308", u_if.o_if_pc); end
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (u_if.o_fetch_req !== 1'b0) begin errors++; $display("FAIL ar_boot_req got %b exp 0", u_if.o_fetch_req); end
    tick();
    checks++; if (u_if.o_fetch_req !== 1'b1) begin errors++; $display("FAIL ar_run_req got %b exp 1", u_if.o_fetch_req); end
    checks++; if (u_if.o_if_pc !== RST_PC) begin errors++; $display("FAIL ar_run_pc got %h exp %h", u_if.o_if_pc, RST_PC); end
    checks++; if (u_if.o_id_valid !== 1'b0) begin errors++; $display("FAIL ar_no_entry got %b exp 0", u_if.o_id_valid); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_flush = 16'h0;
    u_if.i_fetch_ack      = 1'b0;
    u_if.i_branch_valid   = 1'b0;
    u_if.i_branch_taken   = 1'b0;
    u_if.i_branch_target  = 64'h0;
    u_if.i_ex_redirect    = 1'b0;
    u_if.i_ex_redirect_pc = 64'h0;
    u_if.i_id_ready       = 1'b0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    test_reset();
    test_boot_seq();
    test_predict();
    test_hold();
    test_redirect();
    test_wrap();
    test_flush_sat();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
